// File: rtl/kmeans_pkg.sv
// Shared widths, FSM state encoding and packed point/accumulator types for the
// k-means centroid update path.
`default_nettype none

package kmeans_pkg;

    localparam int c_coord_num        = 7;
    localparam int c_cordinate_width  = 13;
    localparam int c_accum_cord_width = 22;
    localparam int c_count_width      = 10;
    localparam int c_centroid_num     = 8;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_READ  = 3'd1,
        S_LOAD  = 3'd2,
        S_DIV   = 3'd3,
        S_WRITE = 3'd4,
        S_NEXT  = 3'd5,
        S_DONE  = 3'd6
    } div_state_e;

    typedef logic [c_coord_num-1:0][c_cordinate_width-1:0]  point_t;
    typedef logic [c_coord_num-1:0][c_accum_cord_width-1:0] accum_t;

endpackage

`default_nettype wire

// File: rtl/centroid_div_lane.sv
// One restoring unsigned divider lane: load captures the operands, each step
// retires one quotient bit MSB first; the output saturates to the coordinate width.
`default_nettype none

module centroid_div_lane #(
    parameter int accum_cord_width = 22,
    parameter int count_width      = 10,
    parameter int cordinate_width  = 13
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        load_i,
    input  logic                        step_i,
    input  logic [accum_cord_width-1:0] dividend_i,
    input  logic [count_width-1:0]      divisor_i,
    output logic [cordinate_width-1:0]  quotient_o
);

    // quo_q starts as the dividend and is shifted left, quotient bits enter at the LSB.
    logic [accum_cord_width-1:0] quo_q, quo_d;
    logic [count_width-1:0]      rem_q, rem_d;
    logic [count_width-1:0]      div_q, div_d;
    logic [count_width:0]        w_trial;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            quo_q <= '0;
            rem_q <= '0;
            div_q <= '0;
        end else begin
            quo_q <= quo_d;
            rem_q <= rem_d;
            div_q <= div_d;
        end
    end

    always_comb begin
        quo_d   = quo_q;
        rem_d   = rem_q;
        div_d   = div_q;
        w_trial = {rem_q, quo_q[accum_cord_width-1]};
        if (load_i) begin
            quo_d = dividend_i;
            rem_d = '0;
            div_d = divisor_i;
        end else if (step_i) begin
            if (w_trial >= {1'b0, div_q}) begin
                rem_d = count_width'(w_trial - {1'b0, div_q});
                quo_d = {quo_q[accum_cord_width-2:0], 1'b1};
            end else begin
                rem_d = w_trial[count_width-1:0];
                quo_d = {quo_q[accum_cord_width-2:0], 1'b0};
            end
        end
    end

    assign quotient_o = (|quo_q[accum_cord_width-1:cordinate_width]) ? '1
                                                                     : quo_q[cordinate_width-1:0];

endmodule

`default_nettype wire

// File: rtl/centroid_divider.sv
// Sweeps all centroids once per k-means iteration, dividing each accumulated
// coordinate sum by its point count and writing the new centroid back.
`default_nettype none

module centroid_divider
    import kmeans_pkg::*;
#(
    parameter int accum_width      = c_coord_num * c_accum_cord_width,
    parameter int dataWidth        = c_coord_num * c_cordinate_width,
    parameter int centroid_num     = c_centroid_num,
    parameter int accum_cord_width = c_accum_cord_width,
    parameter int cordinate_width  = c_cordinate_width,
    parameter int count_width      = c_count_width,
    parameter int addrWidth        = 8,
    localparam int idx_width       = (centroid_num > 1) ? $clog2(centroid_num) : 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    output logic                   busy,
    output logic                   done,
    output logic                   acc_rd_en,
    output logic [idx_width-1:0]   acc_rd_addr,
    input  logic [accum_width-1:0] acc_rd_data,
    input  logic [count_width-1:0] cnt_rd_data,
    output logic                   cent_wr_en,
    output logic [addrWidth-1:0]   cent_wr_addr,
    output logic [dataWidth-1:0]   cent_wr_data
);

    localparam int bit_cnt_width = $clog2(accum_cord_width);
    localparam logic [bit_cnt_width-1:0] c_last_bit = bit_cnt_width'(accum_cord_width - 1);
    localparam logic [idx_width-1:0]     c_last_idx = idx_width'(centroid_num - 1);

    div_state_e               state_q, state_d;
    logic [idx_width-1:0]     index_q, index_d;
    logic [bit_cnt_width-1:0] bit_cnt_q, bit_cnt_d;
    logic                     skip_q, skip_d;
    logic [dataWidth-1:0]     wr_hold_q, wr_hold_d;

    logic   w_load;
    logic   w_step;
    accum_t w_sums;
    point_t w_quot;

    assign w_sums = acc_rd_data;

    generate
        for (genvar g = 0; g < c_coord_num; g++) begin : g_lane
            centroid_div_lane #(
                .accum_cord_width (accum_cord_width),
                .count_width      (count_width),
                .cordinate_width  (cordinate_width)
            ) u_lane (
                .clk        (clk),
                .rst_n      (rst_n),
                .load_i     (w_load),
                .step_i     (w_step),
                .dividend_i (w_sums[g]),
                .divisor_i  (cnt_rd_data),
                .quotient_o (w_quot[g])
            );
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            index_q   <= '0;
            bit_cnt_q <= '0;
            skip_q    <= 1'b0;
            wr_hold_q <= '0;
        end else begin
            state_q   <= state_d;
            index_q   <= index_d;
            bit_cnt_q <= bit_cnt_d;
            skip_q    <= skip_d;
            wr_hold_q <= wr_hold_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        index_d   = index_q;
        bit_cnt_d = bit_cnt_q;
        skip_d    = skip_q;
        wr_hold_d = wr_hold_q;
        w_load    = 1'b0;
        w_step    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    index_d = '0;
                    state_d = S_READ;
                end
            end
            S_READ: state_d = S_LOAD;
            S_LOAD: begin
                // A zero-count slot passes through WRITE with the strobe masked,
                // so it costs four cycles and leaves the stored centroid alone.
                bit_cnt_d = '0;
                skip_d    = (cnt_rd_data == '0);
                if (cnt_rd_data == '0) begin
                    state_d = S_WRITE;
                end else begin
                    w_load  = 1'b1;
                    state_d = S_DIV;
                end
            end
            S_DIV: begin
                w_step    = 1'b1;
                bit_cnt_d = bit_cnt_q + 1'b1;
                if (bit_cnt_q == c_last_bit) begin
                    state_d = S_WRITE;
                end
            end
            S_WRITE: begin
                if (!skip_q) begin
                    wr_hold_d = w_quot;
                end
                state_d = S_NEXT;
            end
            S_NEXT: begin
                if (index_q == c_last_idx) begin
                    state_d = S_DONE;
                end else begin
                    index_d = index_q + 1'b1;
                    state_d = S_READ;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    assign busy         = (state_q != S_IDLE) && (state_q != S_DONE);
    assign done         = (state_q == S_DONE);
    assign acc_rd_en    = (state_q == S_READ);
    assign acc_rd_addr  = acc_rd_en ? index_q : '0;
    assign cent_wr_en   = (state_q == S_WRITE) && !skip_q;
    assign cent_wr_addr = cent_wr_en ? addrWidth'(index_q) : '0;
    assign cent_wr_data = cent_wr_en ? w_quot : wr_hold_q;

endmodule

`default_nettype wire

// File: tb/tb_centroid_divider.sv
// Directed and randomized sweeps of centroid_divider against a floor-division
// model with cycle-accurate write and done timing.
`default_nettype none

module tb_centroid_divider;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    logic start8 = 1'b0;
    logic start1 = 1'b0;
    logic sel = 1'b0;

    always #5 clk = ~clk;

    logic [153:0] acc_rd_data = '0;
    logic [9:0]   cnt_rd_data = '0;

    logic        busy8, done8, rd_en8, wr_en8;
    logic [2:0]  rd_addr8;
    logic [7:0]  wr_addr8;
    logic [90:0] wr_data8;
    logic        busy1, done1, rd_en1, wr_en1;
    logic [0:0]  rd_addr1;
    logic [7:0]  wr_addr1;
    logic [90:0] wr_data1;

    centroid_divider dut (
        .clk(clk), .rst_n(rst_n), .start(start8), .busy(busy8), .done(done8),
        .acc_rd_en(rd_en8), .acc_rd_addr(rd_addr8), .acc_rd_data(acc_rd_data),
        .cnt_rd_data(cnt_rd_data), .cent_wr_en(wr_en8), .cent_wr_addr(wr_addr8),
        .cent_wr_data(wr_data8)
    );

    centroid_divider #(.centroid_num(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .busy(busy1), .done(done1),
        .acc_rd_en(rd_en1), .acc_rd_addr(rd_addr1), .acc_rd_data(acc_rd_data),
        .cnt_rd_data(cnt_rd_data), .cent_wr_en(wr_en1), .cent_wr_addr(wr_addr1),
        .cent_wr_data(wr_data1)
    );

    logic        m_busy, m_done, m_rd_en, m_wr_en;
    logic [2:0]  m_rd_addr;
    logic [7:0]  m_wr_addr;
    logic [90:0] m_wr_data;

    always_comb begin
        m_busy    = sel ? busy1 : busy8;
        m_done    = sel ? done1 : done8;
        m_rd_en   = sel ? rd_en1 : rd_en8;
        m_rd_addr = sel ? {2'b00, rd_addr1} : rd_addr8;
        m_wr_en   = sel ? wr_en1 : wr_en8;
        m_wr_addr = sel ? wr_addr1 : wr_addr8;
        m_wr_data = sel ? wr_data1 : wr_data8;
    end

    logic [153:0] acc_mem [8];
    logic [9:0]   cnt_mem [8];

    always @(posedge clk) begin
        if (m_rd_en) begin
            acc_rd_data <= acc_mem[m_rd_addr];
            cnt_rd_data <= cnt_mem[m_rd_addr];
        end
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int          wq_cyc[$];
    int          wq_addr[$];
    logic [90:0] wq_data[$];
    int          done_q[$];
    int          busy_n, busy_first;

    // Cycle k is the interval ending at the k-th rising edge.
    always @(negedge clk) begin
        if (m_wr_en) begin
            wq_cyc.push_back(cyc + 1);
            wq_addr.push_back(int'(m_wr_addr));
            wq_data.push_back(m_wr_data);
        end
        if (m_done) done_q.push_back(cyc + 1);
        if (m_busy) begin
            if (busy_n == 0) busy_first = cyc + 1;
            busy_n++;
        end
    end

    int vec = 0;
    int err = 0;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        vec++;
        assert (obs === exp) else begin
            err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [90:0] model(input logic [153:0] s, input logic [9:0] c);
        logic [90:0] r;
        int unsigned q;
        r = '0;
        for (int i = 0; i < 7; i++) begin
            q = 32'(s[i*22 +: 22]) / 32'(c);
            if (q > 8191) q = 8191;
            r[i*13 +: 13] = 13'(q);
        end
        return r;
    endfunction

    function automatic logic [153:0] pack7(input int v[7]);
        logic [153:0] r;
        for (int i = 0; i < 7; i++) r[i*22 +: 22] = 22'(v[i]);
        return r;
    endfunction

    task automatic clear_mon();
        wq_cyc.delete(); wq_addr.delete(); wq_data.delete(); done_q.delete();
        busy_n = 0; busy_first = -1;
    endtask

    task automatic set_start(input logic v);
        if (sel) start1 = v; else start8 = v;
    endtask

    task automatic fill_random();
        for (int i = 0; i < 8; i++) begin
            for (int j = 0; j < 7; j++) acc_mem[i][j*22 +: 22] = 22'($urandom_range(0, 22'h3FFFFF));
            cnt_mem[i] = 10'($urandom_range(1, 1023));
        end
    endtask

    // Launch a sweep; optionally fire extra start pulses mid-sweep and on DONE.
    task automatic run_sweep(input logic one, input logic inject, output int t);
        logic got;
        clear_mon();
        sel = one;
        @(negedge clk);
        t = cyc + 1;
        set_start(1'b1);
        @(negedge clk);
        set_start(1'b0);
        got = 1'b0;
        for (int k = 0; k < 600 && !got; k++) begin
            if (m_done) begin
                got = 1'b1;
                if (inject) set_start(1'b1);
            end else if (inject && (k == 30 || k == 150)) begin
                set_start(1'b1);
            end
            @(negedge clk);
            set_start(1'b0);
        end
        repeat (6) @(negedge clk);
    endtask

    task automatic check_sweep(input string nm, input int n, input int t);
        int c, nw;
        c  = t + 1;
        nw = 0;
        for (int i = 0; i < n; i++) begin
            if (cnt_mem[i] != 0) begin
                chk($sformatf("%s_wcyc%0d", nm, i), (nw < wq_cyc.size()) ? wq_cyc[nw] : -1, c + 24);
                chk($sformatf("%s_waddr%0d", nm, i), (nw < wq_addr.size()) ? wq_addr[nw] : -1, i);
                chk($sformatf("%s_wdata%0d", nm, i), (nw < wq_data.size()) ? wq_data[nw] : '1,
                    model(acc_mem[i], cnt_mem[i]));
                nw++;
                c += 26;
            end else begin
                c += 4;
            end
        end
        chk({nm, "_nwrites"}, wq_cyc.size(), nw);
        chk({nm, "_done"}, (done_q.size() == 1) ? done_q[0] : -1, c);
        chk({nm, "_busy_cycles"}, busy_n, c - t - 1);
        chk({nm, "_busy_first"}, busy_first, t + 1);
    endtask

    int t;

    initial begin
        clear_mon();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_busy", busy8, 1'b0);
        chk("rst_done", done8, 1'b0);
        chk("rst_rd_en", rd_en8, 1'b0);
        chk("rst_rd_addr", rd_addr8, 3'd0);
        chk("rst_wr_en", wr_en8, 1'b0);
        chk("rst_wr_addr", wr_addr8, 8'd0);
        chk("rst_wr_data", wr_data8, 91'd0);
        rst_n = 1'b1;

        // Single-centroid instance: sums 100, count 4.
        acc_mem[0] = pack7('{100, 100, 100, 100, 100, 100, 100});
        cnt_mem[0] = 10'd4;
        run_sweep(1'b1, 1'b0, t);
        check_sweep("one", 1, t);
        chk("one_value", (wq_data.size() > 0) ? wq_data[0] : '1, {7{13'd25}});
        chk("one_done_abs", (done_q.size() > 0) ? done_q[0] : -1, t + 27);

        // Directed boundaries with a zero-count slot at index 2.
        fill_random();
        acc_mem[0] = pack7('{10, 11, 0, 1, 22, 7, 8191});
        cnt_mem[0] = 10'd3;
        acc_mem[1] = {7{22'h3FFFFF}};
        cnt_mem[1] = 10'd512;
        cnt_mem[2] = 10'd0;
        acc_mem[3] = {7{22'h3FFFFF}};
        cnt_mem[3] = 10'd1;
        acc_mem[4] = {7{22'h3FFFFF}};
        cnt_mem[4] = 10'd1023;
        acc_mem[5] = pack7('{4096000, 4095999, 4095500, 0, 499, 500, 4096499});
        cnt_mem[5] = 10'd500;
        acc_mem[6] = '0;
        cnt_mem[6] = 10'd1023;
        run_sweep(1'b0, 1'b0, t);
        check_sweep("dir", 8, t);
        chk("dir_trunc", (wq_data.size() > 0) ? wq_data[0] : '1,
            {13'd2730, 13'd2, 13'd7, 13'd0, 13'd0, 13'd3, 13'd3});
        chk("dir_exact_max", (wq_data.size() > 1) ? wq_data[1] : '1, {7{13'h1FFF}});
        chk("dir_sat_cnt1", (wq_data.size() > 2) ? wq_data[2] : '1, {7{13'h1FFF}});
        chk("dir_cnt1023", (wq_data.size() > 3) ? wq_data[3] : '1, {7{13'd4100}});
        chk("dir_done_abs", (done_q.size() > 0) ? done_q[0] : -1, t + 1 + 7 * 26 + 4);

        // Random full sweeps, the second one with stray start pulses.
        for (int r = 0; r < 2; r++) begin
            fill_random();
            run_sweep(1'b0, r[0], t);
            check_sweep($sformatf("rnd%0d", r), 8, t);
            chk($sformatf("rnd%0d_done_abs", r), (done_q.size() > 0) ? done_q[0] : -1, t + 209);
        end

        // Reset in the middle of dividing index 5.
        fill_random();
        clear_mon();
        sel = 1'b0;
        @(negedge clk);
        t = cyc + 1;
        start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        for (int k = 0; k < 400 && (cyc + 1 < t + 143); k++) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_busy", busy8, 1'b0);
        chk("mid_rst_wr_en", wr_en8, 1'b0);
        chk("mid_rst_wr_data", wr_data8, 91'd0);
        chk("mid_rst_rd_en", rd_en8, 1'b0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (40) @(negedge clk);
        chk("mid_rst_nwrites", wq_cyc.size(), 5);
        chk("mid_rst_last_addr", (wq_addr.size() > 0) ? wq_addr[wq_addr.size()-1] : -1, 4);
        chk("mid_rst_no_done", done_q.size(), 0);
        run_sweep(1'b0, 1'b0, t);
        check_sweep("post_rst", 8, t);

        $display("== %0d vectors applied, %0d miscompares ==", vec, err);
        $finish;
    end

endmodule

`default_nettype wire
